cga_vram_arbiter: RTL and testbench
===================================

# cga_vram_arbiter

Shares the single CGA video RAM port between the display fetch path (driven by `cga_sequencer`) and CPU memory cycles from the ISA bus. CPU cycles are held off with wait states (`bus_rdy` low) until the sequencer reports a free slot. The block sits between the CGA core's `ram_a`/`ram_we_l`/`ram_d` nets and the external VRAM, and generates the ISA `bus_rdy` that the core ties high today.

## Interface
- `ACCESS_CYCLES`, 2: clocks the RAM port is held for one CPU access; legal range 1–7.
- `USE_BUS_WAIT`, 1: when 0, `bus_rdy` is forced to 1; arbitration still runs and a late CPU cycle may be lost.

- `clk`  in  1  core clock, same as the CGA sequencer.
- `reset`  in  1  asynchronous, active-high.
- `disp_slot`  in  1  sequencer owns VRAM this cycle (display fetch).
- `isa_window`  in  1  sequencer permits a CPU access to start (`isa_op_enable`).
- `disp_addr`  in  19  display fetch address.
- `cpu_req`  in  1  CPU memory cycle active (synced `~memr_l | ~memw_l` with chip-select).
- `cpu_we`  in  1  1 = write; sampled with `cpu_req`.
- `cpu_addr`  in  15  CPU offset in the framebuffer.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  registered read data.
- `bus_rdy`  out  1  ISA ready; low inserts wait states.
- `ram_a`  out  19  VRAM address.
- `ram_we_l`  out  1  VRAM write strobe, active low.
- `ram_dout`  out  8  VRAM write data.
- `ram_din`  in  8  VRAM read data.
- `disp_data`  out  8  data forwarded to the pixel pipeline (`ram_din` passthrough).
- `snow_hit`  out  1  one-clock pulse: a CPU access overlapped a display slot.

## Operation
- States: IDLE, WAIT_SLOT, ACCESS, DONE.
- **IDLE:**
  - `cpu_req`=1 → WAIT_SLOT.
  - `cpu_we`, `cpu_addr` and `cpu_wdata` are latched on this edge.
- **WAIT_SLOT:**
  - `cpu_req`=0 → IDLE; no RAM access is made.
  - `isa_window`=1 and `disp_slot`=0 → ACCESS, with the access counter cleared.
- **ACCESS:**
  - `ram_a` = {4'h0, latched `cpu_addr`}; `ram_dout` = latched data.
  - `ram_we_l` = ~latched `cpu_we` for every ACCESS cycle.
  - The counter increments each clock. At count ACCESS_CYCLES-1, `cpu_rdata` <= `ram_din` (reads only) and the state moves to DONE.
- **DONE:**
  - `ram_we_l`=1.
  - `cpu_req`=0 → IDLE.
- **Outside ACCESS:** `ram_a` = `disp_addr`, `ram_we_l`=1, `ram_dout`=0.
- **`bus_rdy`:** combinational, = ~(`cpu_req` & state≠DONE) when `USE_BUS_WAIT`=1.
- **Display collision in ACCESS** (`disp_slot` rises, `CGA_SNOW_EN` undefined):
  - The display wins: `ram_a` reverts to `disp_addr` that same cycle and `ram_we_l`=1.
  - State → WAIT_SLOT and the access restarts from count 0 later.
  - A partial write is simply repeated.
- `cpu_req` dropping during ACCESS → IDLE next clock; `cpu_rdata` is not updated.
- Reset (async): state=IDLE, counter=0, `cpu_rdata`=0, `ram_we_l`=1, `snow_hit`=0. `ram_a` follows `disp_addr` and `bus_rdy` follows its equation. A reset mid-ACCESS deasserts `ram_we_l` immediately.

## Timing
- Minimum CPU latency: `cpu_req` is seen in IDLE at edge N and the state is WAIT_SLOT at N+1.
- With a slot free, ACCESS occupies N+2..N+1+ACCESS_CYCLES. DONE and `bus_rdy`=1 follow at N+2+ACCESS_CYCLES (4 wait clocks with the default).
- `cpu_rdata` is valid from DONE entry and holds until the next read completes.
- `disp_data` = `ram_din` with zero added latency; the sequencer's own pipeline timing is unchanged.
- Simultaneous `cpu_req` deassert and slot grant in WAIT_SLOT: deassert wins → IDLE.

## Configuration
- **`CGA_SNOW_EN` defined:**
  - ACCESS ignores `disp_slot`; the CPU keeps the port for the full ACCESS_CYCLES.
  - The display reads CPU-addressed data, which is the genuine CGA snow artifact.
  - `snow_hit` pulses for each ACCESS cycle where `disp_slot`=1.
  - WAIT_SLOT still requires `isa_window`=1 but not `disp_slot`=0.
- **Undefined:** collision behaviour as in Operation; `snow_hit` is tied 0.

## Test plan
- **Reset:** assert `reset` mid-ACCESS during a write → `ram_we_l`=1 within the same cycle, state IDLE, `cpu_rdata`=8'h00.
- **Basic write:** `cpu_req`=1, `cpu_we`=1, addr 15'h0123, data 8'hA5, `isa_window`=1, `disp_slot`=0.
  - `ram_a`=19'h00123 and `ram_we_l`=0 for exactly 2 clocks.
  - `bus_rdy` low for 4 clocks, then 1 until `cpu_req` drops.
- **Read:** preload `ram_din`=8'h3C at 19'h07FFF and read 15'h7FFF → `cpu_rdata`=8'h3C on DONE entry.
- **Held off:** `isa_window`=0 for 10 clocks after `cpu_req` → `bus_rdy` stays 0 and `ram_a` tracks `disp_addr` throughout.
- **Collision:**
  - Without `CGA_SNOW_EN`: raise `disp_slot` in the first ACCESS cycle → `ram_a`=`disp_addr` that cycle and the access restarts, 2 full ACCESS cycles later.
  - With `CGA_SNOW_EN`: the same stimulus gives `snow_hit`=1 for 1 clock and no restart.
- **Abort:** drop `cpu_req` in WAIT_SLOT → no `ram_we_l` pulse and the state returns to IDLE.

Source files
------------

// File: rtl/cga_vram_arbiter.sv
// Arbitrates the single CGA video RAM port between display fetch and ISA CPU cycles.
// Define CGA_SNOW_EN to let CPU accesses keep the port through display slots (snow).
module cga_vram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter bit          USE_BUS_WAIT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_slot,
  input  logic        isa_window,
  input  logic [18:0] disp_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        bus_rdy,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [7:0]  disp_data,
  output logic        snow_hit
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    ACCESS,
    DONE
  } state_e;

  localparam logic [2:0] LastCount = 3'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;

  logic dispWins;
  logic slotFree;
  logic lastBeat;
  logic captureReq;
  logic ramOwned;

  // With snow enabled the display never preempts an access already on the port.
`ifdef CGA_SNOW_EN
  assign dispWins = 1'b0;
  assign slotFree = isa_window;
`else
  assign dispWins = disp_slot;
  assign slotFree = isa_window & ~disp_slot;
`endif

  assign lastBeat   = (cnt_q == LastCount);
  assign captureReq = (state_q == IDLE) & cpu_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) state_d = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (!cpu_req)      state_d = IDLE;
        else if (slotFree) state_d = ACCESS;
      end
      ACCESS: begin
        if (!cpu_req)      state_d = IDLE;
        else if (dispWins) state_d = WAIT_SLOT;
        else if (lastBeat) state_d = DONE;
      end
      DONE: begin
        if (!cpu_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter only survives while an access continues; any exit restarts it at zero.
  always_comb begin
    cnt_d   = 3'd0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if ((state_q == ACCESS) && (state_d == ACCESS)) begin
      cnt_d = cnt_q + 3'd1;
    end
    if (captureReq) begin
      we_d    = cpu_we;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end
    if ((state_q == ACCESS) && (state_d == DONE) && !we_q) begin
      rdata_d = ram_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 15'h0000;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ramOwned = (state_q == ACCESS) & ~dispWins;

  // Port outputs are decoded straight from state so reset releases the write strobe at once.
  always_comb begin
    ram_a    = disp_addr;
    ram_we_l = 1'b1;
    ram_dout = 8'h00;
    snow_hit = 1'b0;
    if (ramOwned) begin
      ram_a    = {4'h0, addr_q};
      ram_we_l = ~we_q;
      ram_dout = wdata_q;
    end
`ifdef CGA_SNOW_EN
    snow_hit = (state_q == ACCESS) & disp_slot;
`endif
  end

  assign bus_rdy   = USE_BUS_WAIT ? ~(cpu_req & (state_q != DONE)) : 1'b1;
  assign cpu_rdata = rdata_q;
  assign disp_data = ram_din;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter: a per-cycle vector table plus hand-written
// sequences for hold-off, abort, display collision and asynchronous reset.
module tb_cga_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        disp_slot;
  logic        isa_window;
  logic [18:0] disp_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        bus_rdy;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [7:0]  disp_data;
  logic        snow_hit;

  int passCount;
  int checkCount;

  cga_vram_arbiter #(
    .ACCESS_CYCLES(2),
    .USE_BUS_WAIT (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .disp_slot (disp_slot),
    .isa_window(isa_window),
    .disp_addr (disp_addr),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .bus_rdy   (bus_rdy),
    .ram_a     (ram_a),
    .ram_we_l  (ram_we_l),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .disp_data (disp_data),
    .snow_hit  (snow_hit)
  );

  // VRAM model: one preloaded cell, every other address returns a pattern of its low byte.
  function automatic logic [7:0] memModel(input logic [18:0] a);
    if (a == 19'h07FFF) return 8'h3C;
    return a[7:0] ^ 8'h5A;
  endfunction

  assign ram_din = memModel(ram_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        win;
    logic        slot;
    logic [18:0] daddr;
    logic        expRdy;
    logic [18:0] expRamA;
    logic        expWeL;
    logic [7:0]  expDout;
    logic [7:0]  expRdata;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [14:0] addr,
                               input logic [7:0] wdata, input logic win, input logic slot,
                               input logic [18:0] daddr);
    cpu_req    = req;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    isa_window = win;
    disp_slot  = slot;
    disp_addr  = daddr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 15'h0, 8'h00, 1'b0, 1'b0, 19'h00000);

    //           req  we    addr     wdata  win   slot  daddr      rdy   ramA       weL   dout   rdata
    vecs[0]  = '{1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 19'h12345, 1'b1, 19'h12345, 1'b1, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h12346, 1'b0, 19'h12346, 1'b1, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h12347, 1'b0, 19'h12347, 1'b1, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h12348, 1'b0, 19'h00123, 1'b0, 8'hA5, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h12349, 1'b0, 19'h00123, 1'b0, 8'hA5, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h1234A, 1'b1, 19'h1234A, 1'b1, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h1234B, 1'b1, 19'h1234B, 1'b1, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 15'h0123, 8'hA5, 1'b1, 1'b0, 19'h1234C, 1'b1, 19'h1234C, 1'b1, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00010, 1'b0, 19'h00010, 1'b1, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00011, 1'b0, 19'h00011, 1'b1, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00012, 1'b0, 19'h07FFF, 1'b1, 8'h77, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00013, 1'b0, 19'h07FFF, 1'b1, 8'h77, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00014, 1'b1, 19'h00014, 1'b1, 8'h00, 8'h3C};
    vecs[13] = '{1'b0, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00015, 1'b1, 19'h00015, 1'b1, 8'h00, 8'h3C};
    vecs[14] = '{1'b0, 1'b0, 15'h7FFF, 8'h77, 1'b1, 1'b0, 19'h00016, 1'b1, 19'h00016, 1'b1, 8'h00, 8'h3C};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset we_l", 32'(ram_we_l), 32'h1);
    checkOutput("reset rdata", 32'(cpu_rdata), 32'h00);
    checkOutput("reset snow", 32'(snow_hit), 32'h0);
    checkOutput("reset ram_a", 32'(ram_a), 32'h00000);
    reset = 1'b0;

    // Basic write then read, one table row per clock.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].win, vecs[i].slot, vecs[i].daddr);
      #1;
      checkOutput($sformatf("vec%0d bus_rdy", i), 32'(bus_rdy), 32'(vecs[i].expRdy));
      checkOutput($sformatf("vec%0d ram_a", i), 32'(ram_a), 32'(vecs[i].expRamA));
      checkOutput($sformatf("vec%0d ram_we_l", i), 32'(ram_we_l), 32'(vecs[i].expWeL));
      checkOutput($sformatf("vec%0d ram_dout", i), 32'(ram_dout), 32'(vecs[i].expDout));
      checkOutput($sformatf("vec%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d disp_data", i), 32'(disp_data),
                  32'(memModel(vecs[i].expRamA)));
      step();
    end

    // Held off: no ISA window for 10 clocks, then abort with the window opening.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 15'h0100, 8'h11, 1'b0, 1'b0, 19'h40000 + 19'(i));
      #1;
      checkOutput($sformatf("hold%0d bus_rdy", i), 32'(bus_rdy), 32'h0);
      checkOutput($sformatf("hold%0d ram_a", i), 32'(ram_a), 32'h40000 + i);
      checkOutput($sformatf("hold%0d we_l", i), 32'(ram_we_l), 32'h1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 15'h0100, 8'h11, 1'b1, 1'b0, 19'h50000 + 19'(i));
      #1;
      checkOutput($sformatf("abort%0d we_l", i), 32'(ram_we_l), 32'h1);
      checkOutput($sformatf("abort%0d ram_a", i), 32'(ram_a), 32'h50000 + i);
      checkOutput($sformatf("abort%0d bus_rdy", i), 32'(bus_rdy), 32'h1);
      step();
    end

    // Collision: display slot rises in the first ACCESS cycle of a write.
    applyStimulus(1'b1, 1'b1, 15'h0055, 8'h5A, 1'b1, 1'b0, 19'h60000);
    #1;
    checkOutput("coll idle bus_rdy", 32'(bus_rdy), 32'h0);
    step();
    disp_addr = 19'h60001;
    #1;
    checkOutput("coll wait we_l", 32'(ram_we_l), 32'h1);
    step();
    disp_slot = 1'b1;
    disp_addr = 19'h60002;
    #1;
`ifdef CGA_SNOW_EN
    checkOutput("snow acc0 ram_a", 32'(ram_a), 32'h00055);
    checkOutput("snow acc0 we_l", 32'(ram_we_l), 32'h0);
    checkOutput("snow acc0 snow_hit", 32'(snow_hit), 32'h1);
    step();
    disp_slot = 1'b0;
    disp_addr = 19'h60003;
    #1;
    checkOutput("snow acc1 ram_a", 32'(ram_a), 32'h00055);
    checkOutput("snow acc1 we_l", 32'(ram_we_l), 32'h0);
    checkOutput("snow acc1 snow_hit", 32'(snow_hit), 32'h0);
    step();
    #1;
    checkOutput("snow done bus_rdy", 32'(bus_rdy), 32'h1);
    checkOutput("snow done we_l", 32'(ram_we_l), 32'h1);
`else
    checkOutput("coll acc0 ram_a", 32'(ram_a), 32'h60002);
    checkOutput("coll acc0 we_l", 32'(ram_we_l), 32'h1);
    checkOutput("coll acc0 dout", 32'(ram_dout), 32'h00);
    checkOutput("coll acc0 snow_hit", 32'(snow_hit), 32'h0);
    step();
    disp_slot = 1'b0;
    disp_addr = 19'h60003;
    #1;
    checkOutput("coll rewait ram_a", 32'(ram_a), 32'h60003);
    checkOutput("coll rewait we_l", 32'(ram_we_l), 32'h1);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput($sformatf("coll retry%0d ram_a", i), 32'(ram_a), 32'h00055);
      checkOutput($sformatf("coll retry%0d we_l", i), 32'(ram_we_l), 32'h0);
      checkOutput($sformatf("coll retry%0d dout", i), 32'(ram_dout), 32'h5A);
      checkOutput($sformatf("coll retry%0d bus_rdy", i), 32'(bus_rdy), 32'h0);
      step();
    end
    #1;
    checkOutput("coll done bus_rdy", 32'(bus_rdy), 32'h1);
    checkOutput("coll done we_l", 32'(ram_we_l), 32'h1);
`endif
    cpu_req = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of a write access.
    applyStimulus(1'b1, 1'b1, 15'h0200, 8'hC3, 1'b1, 1'b0, 19'h70000);
    step();
    step();
    #1;
    checkOutput("rst pre we_l", 32'(ram_we_l), 32'h0);
    checkOutput("rst pre rdata", 32'(cpu_rdata), 32'h3C);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst async we_l", 32'(ram_we_l), 32'h1);
    checkOutput("rst async ram_a", 32'(ram_a), 32'h70000);
    checkOutput("rst async rdata", 32'(cpu_rdata), 32'h00);
    checkOutput("rst async bus_rdy", 32'(bus_rdy), 32'h0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("rst idle we_l", 32'(ram_we_l), 32'h1);
    step();
    #1;
    checkOutput("rst wait we_l", 32'(ram_we_l), 32'h1);
    step();
    #1;
    checkOutput("rst access we_l", 32'(ram_we_l), 32'h0);
    checkOutput("rst access ram_a", 32'(ram_a), 32'h00200);
    cpu_req = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
